// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   - DW / RA: datapath and register-address widths.
//   - Opcode constants and element-width (ww) encodings.
//   - slot_t: one issue-buffer entry.
//   - occ_state_e: occupancy states of the two-entry buffer.
//   - slot_snoop(): applies a writeback to an entry's operands.
// All buses are big-endian: bit 0 is the MSB.
package alu_pkg;

   localparam int DW = 64;
   localparam int RA = 5;

   localparam logic [0:1] WW_B = 2'b00;
   localparam logic [0:1] WW_H = 2'b01;
   localparam logic [0:1] WW_W = 2'b10;
   localparam logic [0:1] WW_D = 2'b11;

   localparam logic [0:5] OP_ADD = 6'd0;
   localparam logic [0:5] OP_SUB = 6'd1;
   localparam logic [0:5] OP_AND = 6'd2;
   localparam logic [0:5] OP_OR  = 6'd3;
   localparam logic [0:5] OP_XOR = 6'd4;
   localparam logic [0:5] OP_SLL = 6'd5;
   localparam logic [0:5] OP_SRL = 6'd6;
   localparam logic [0:5] OP_SRA = 6'd7;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_state_e;

   typedef struct packed {
      logic            valid;
      logic [0:5]      op;
      logic [0:1]      ww;
      logic [0:4]      shamt;
      logic [0:RA-1]   ra;
      logic [0:RA-1]   rb;
      logic [0:RA-1]   rd;
      logic [0:DW-1]   data_a;
      logic [0:DW-1]   data_b;
      logic            pend_a;
      logic            pend_b;
   } slot_t;

   // A writeback to a source register of a valid entry refreshes that
   // operand and resolves any pending wait on it. When ra == rb both
   // operands take the same value.
   function automatic slot_t slot_snoop(slot_t s, logic we,
                                        logic [0:RA-1] addr,
                                        logic [0:DW-1] data);
      slot_t r;
      r = s;
      if (s.valid && we) begin
         if (addr == s.ra) begin
            r.data_a = data;
            r.pend_a = 1'b0;
         end
         if (addr == s.rb) begin
            r.data_b = data;
            r.pend_b = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/issue_slot.sv
// issue_slot: one entry of the issue buffer.
//   clk_i, reset_i   clock, asynchronous active-high reset
//   load_i           write load_data_i into the entry (wins over clr_i)
//   clr_i            drop the entry
//   load_data_i      entry to load; taken as-is, no snoop applied
//   wb_we_i/addr/data writeback port, snooped every cycle
//   slot_o           registered entry contents
module issue_slot
   import alu_pkg::*;
(
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          load_i,
   input  logic          clr_i,
   input  slot_t         load_data_i,
   input  logic          wb_we_i,
   input  logic [0:RA-1] wb_addr_i,
   input  logic [0:DW-1] wb_data_i,
   output slot_t         slot_o
);

   slot_t slot_q;
   slot_t slot_d;

   // Loaded data is not snooped here: the top already resolved the
   // same-cycle writeback when it built the entry, and a pended source
   // must wait for its own producer, not an older write in this cycle.
   always_comb begin
      slot_d = slot_snoop(slot_q, wb_we_i, wb_addr_i, wb_data_i);
      if (clr_i) begin
         slot_d.valid  = 1'b0;
         slot_d.pend_a = 1'b0;
         slot_d.pend_b = 1'b0;
      end
      if (load_i) begin
         slot_d = load_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot_o = slot_q;

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-entry issue buffer in front of the ALU.
//   clk, reset                 clock, asynchronous active-high reset
//   id_valid/id_ready          decode handshake (id_ready registered)
//   id_op/ww/shamt/rA/rB/rD    decoded instruction
//   id_dataA/B                 register-file read data
//   wb_we/addr/data            writeback port (forwarding and snoop)
//   ex_valid/ex_ready          ALU handshake
//   oprA/oprB/op/ww/shift_amount/ex_rD  head entry to the ALU
//   dbg_state                  occupancy state
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. Valid does not depend on ready; once ex_valid is high
// the head outputs hold until the transfer. id_ready depends only on
// registered occupancy, never on ex_ready.
module alu_issue_stage
   import alu_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          id_valid,
   output logic          id_ready,
   input  logic [0:5]    id_op,
   input  logic [0:1]    id_ww,
   input  logic [0:4]    id_shamt,
   input  logic [0:RA-1] id_rA,
   input  logic [0:RA-1] id_rB,
   input  logic [0:RA-1] id_rD,
   input  logic [0:DW-1] id_dataA,
   input  logic [0:DW-1] id_dataB,
   input  logic          wb_we,
   input  logic [0:RA-1] wb_addr,
   input  logic [0:DW-1] wb_data,
   output logic          ex_valid,
   input  logic          ex_ready,
   output logic [0:DW-1] oprA,
   output logic [0:DW-1] oprB,
   output logic [0:5]    op,
   output logic [0:1]    ww,
   output logic [0:4]    shift_amount,
   output logic [0:RA-1] ex_rD,
   output logic [1:0]    dbg_state
);

   occ_state_e state_q, state_d;
   logic       id_ready_q;

   slot_t head_slot, skid_slot;
   slot_t new_entry, head_load_data;
   logic  head_load, head_clr, skid_load, skid_clr;
   logic  accept, fire;
   logic  pend_a, pend_b;
   logic  unused_head_src;

   assign ex_valid = head_slot.valid & ~head_slot.pend_a & ~head_slot.pend_b;
   assign accept   = id_valid & id_ready_q;
   assign fire     = ex_valid & ex_ready;

   // A source is pended on any buffered producer, including a head that
   // fires this cycle: its result reaches wb only next cycle.
   always_comb begin
      pend_a = (head_slot.valid && head_slot.rd == id_rA) ||
               (skid_slot.valid && skid_slot.rd == id_rA);
      pend_b = (head_slot.valid && head_slot.rd == id_rB) ||
               (skid_slot.valid && skid_slot.rd == id_rB);

      new_entry        = '0;
      new_entry.valid  = 1'b1;
      new_entry.op     = id_op;
      new_entry.ww     = id_ww;
      new_entry.shamt  = id_shamt;
      new_entry.ra     = id_rA;
      new_entry.rb     = id_rB;
      new_entry.rd     = id_rD;
      new_entry.pend_a = pend_a;
      new_entry.pend_b = pend_b;

      if (!pend_a && wb_we && wb_addr == id_rA) begin
         new_entry.data_a = wb_data;
      end else begin
         new_entry.data_a = id_dataA;
      end
      if (!pend_b && wb_we && wb_addr == id_rB) begin
         new_entry.data_b = wb_data;
      end else begin
         new_entry.data_b = id_dataB;
      end
   end

   // Occupancy FSM and slot steering.
   always_comb begin
      state_d        = state_q;
      head_load      = 1'b0;
      head_clr       = 1'b0;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;
      head_load_data = new_entry;
      case (state_q)
         OCC_EMPTY: begin
            if (accept) begin
               head_load = 1'b1;
               state_d   = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (accept && fire) begin
               head_load = 1'b1;
            end else if (accept) begin
               skid_load = 1'b1;
               state_d   = OCC_FULL;
            end else if (fire) begin
               head_clr = 1'b1;
               state_d  = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            // No accept is possible here (id_ready is low). The skid entry
            // moves up with this cycle's writeback already applied.
            if (fire) begin
               head_load      = 1'b1;
               head_load_data = slot_snoop(skid_slot, wb_we, wb_addr, wb_data);
               skid_clr       = 1'b1;
               state_d        = OCC_ONE;
            end
         end
         default: begin
            state_d = OCC_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= OCC_EMPTY;
         id_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         id_ready_q <= (state_d != OCC_FULL);
      end
   end

   issue_slot u_head (
      .clk_i       (clk),
      .reset_i     (reset),
      .load_i      (head_load),
      .clr_i       (head_clr),
      .load_data_i (head_load_data),
      .wb_we_i     (wb_we),
      .wb_addr_i   (wb_addr),
      .wb_data_i   (wb_data),
      .slot_o      (head_slot)
   );

   issue_slot u_skid (
      .clk_i       (clk),
      .reset_i     (reset),
      .load_i      (skid_load),
      .clr_i       (skid_clr),
      .load_data_i (new_entry),
      .wb_we_i     (wb_we),
      .wb_addr_i   (wb_addr),
      .wb_data_i   (wb_data),
      .slot_o      (skid_slot)
   );

   // Head source addresses are only needed inside the slot for snooping.
   assign unused_head_src = ^{head_slot.ra, head_slot.rb};

   assign id_ready     = id_ready_q;
   assign oprA         = head_slot.data_a;
   assign oprB         = head_slot.data_b;
   assign op           = head_slot.op;
   assign ww           = head_slot.ww;
   assign shift_amount = head_slot.shamt;
   assign ex_rD        = head_slot.rd;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
   import alu_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          reset;
   logic          id_valid, id_ready;
   logic [0:5]    id_op;
   logic [0:1]    id_ww;
   logic [0:4]    id_shamt;
   logic [0:RA-1] id_rA, id_rB, id_rD;
   logic [0:DW-1] id_dataA, id_dataB;
   logic          wb_we;
   logic [0:RA-1] wb_addr;
   logic [0:DW-1] wb_data;
   logic          ex_valid, ex_ready;
   logic [0:DW-1] oprA, oprB;
   logic [0:5]    op;
   logic [0:1]    ww;
   logic [0:4]    shift_amount;
   logic [0:RA-1] ex_rD;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_op(id_op), .id_ww(id_ww), .id_shamt(id_shamt),
      .id_rA(id_rA), .id_rB(id_rB), .id_rD(id_rD),
      .id_dataA(id_dataA), .id_dataB(id_dataB),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .oprA(oprA), .oprB(oprB), .op(op), .ww(ww),
      .shift_amount(shift_amount), .ex_rD(ex_rD),
      .dbg_state(dbg_state)
   );

   // ---------------- reference model ----------------
   // Program-order model: each accepted instruction sees the value of the
   // latest older writer of its sources (arch[]); regs[] is the committed
   // register file that feeds id_data. An entry may issue once every
   // producer it depends on has written back in an earlier cycle.
   typedef struct {
      int          seq;
      logic [5:0]  op;
      logic [1:0]  ww;
      logic [4:0]  sh;
      logic [4:0]  rd;
      logic [63:0] a, b, res;
      int          dep_a, dep_b;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] regs[32];
   logic [63:0] arch[32];
   int          last_wr[32];
   int          busy[32];
   int          wb_cyc[4096];
   int          seq, cyc, n_chk, n_pass;
   logic        nxt_we;
   logic [4:0]  nxt_addr;
   logic [63:0] nxt_data;
   int          nxt_seq;

   // ---------------- scoreboard check ----------------
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      else
         n_pass++;
   endtask

   function automatic logic dep_done(int d);
      return (d < 0) || (wb_cyc[d] < cyc);
   endfunction

   function automatic logic [4:0] pick_rd();
      logic [4:0] r;
      for (int t = 0; t < 64; t++) begin
         r = 5'($urandom_range(0, 7));
         if (busy[r] == 0) return r;
      end
      for (int k = 8; k < 32; k++)
         if (busy[k] == 0) return 5'(k);
      return 5'd31;
   endfunction

   task automatic flush_model();
      exp_q.delete();
      for (int r = 0; r < 32; r++) begin
         arch[r]    = regs[r];
         last_wr[r] = -1;
         busy[r]    = 0;
      end
      nxt_we = 1'b0;
   endtask

   // ---------------- driver: one clock cycle ----------------
   // Entered at posedge+#1; leaves at the next posedge+#1.
   task automatic step(input logic v, input logic [5:0] o, input logic [1:0] w,
                       input logic [4:0] sh, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] rd, input logic [63:0] res, input logic rdy);
      exp_t e;
      logic exp_v;
      if (wb_we) begin
         regs[wb_addr] = wb_data;
         busy[wb_addr] = busy[wb_addr] - 1;
      end
      wb_we   = nxt_we;
      wb_addr = nxt_addr;
      wb_data = nxt_data;
      if (nxt_we) wb_cyc[nxt_seq] = cyc;
      nxt_we   = 1'b0;
      id_valid = v;
      id_op    = o;
      id_ww    = w;
      id_shamt = sh;
      id_rA    = ra;
      id_rB    = rb;
      id_rD    = rd;
      id_dataA = regs[ra];
      id_dataB = regs[rb];
      ex_ready = rdy;

      @(negedge clk);
      chk("id_ready", id_ready, exp_q.size() != 2);
      exp_v = (exp_q.size() > 0) && dep_done(exp_q[0].dep_a) && dep_done(exp_q[0].dep_b);
      chk("ex_valid", ex_valid, exp_v);
      if (ex_valid && ex_ready) begin
         if (exp_q.size() == 0) begin
            chk("fire_when_empty", ex_valid, 0);
         end else begin
            e = exp_q.pop_front();
            chk("oprA", oprA, e.a);
            chk("oprB", oprB, e.b);
            chk("op", op, e.op);
            chk("ww", ww, e.ww);
            chk("shift_amount", shift_amount, e.sh);
            chk("ex_rD", ex_rD, e.rd);
            nxt_we   = 1'b1;
            nxt_addr = e.rd;
            nxt_data = e.res;
            nxt_seq  = e.seq;
         end
      end
      if (id_valid && id_ready) begin
         e.seq   = seq;
         e.op    = o;
         e.ww    = w;
         e.sh    = sh;
         e.rd    = rd;
         e.a     = arch[ra];
         e.b     = arch[rb];
         e.res   = res;
         e.dep_a = last_wr[ra];
         e.dep_b = last_wr[rb];
         arch[rd]    = res;
         last_wr[rd] = seq;
         busy[rd]    = busy[rd] + 1;
         seq++;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 6'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b1);
   endtask

   task automatic check_reset_outputs(input string pfx);
      chk({pfx, "_id_ready"}, id_ready, 1);
      chk({pfx, "_ex_valid"}, ex_valid, 0);
      chk({pfx, "_oprA"}, oprA, 0);
      chk({pfx, "_oprB"}, oprB, 0);
      chk({pfx, "_op"}, op, 0);
      chk({pfx, "_ex_rD"}, ex_rD, 0);
      chk({pfx, "_state"}, dbg_state, OCC_EMPTY);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_chk = 0; n_pass = 0; seq = 0; cyc = 0;
      reset = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
      id_op = '0; id_ww = '0; id_shamt = '0; id_rA = '0; id_rB = '0; id_rD = '0;
      id_dataA = '0; id_dataB = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      nxt_addr = '0; nxt_data = '0; nxt_seq = 0;
      for (int r = 0; r < 32; r++) regs[r] = {$urandom, $urandom};
      for (int s = 0; s < 4096; s++) wb_cyc[s] = 32'h7fff_ffff;
      flush_model();

      #1 reset = 1'b1;
      #2;
      check_reset_outputs("reset");
      chk("reset_ww", ww, 0);
      chk("reset_shamt", shift_amount, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;

      // Independent stream of four.
      for (int k = 0; k < 4; k++)
         step(1'b1, 6'(k + 1), 2'(k), 5'(3 * k + 1), 5'(10 + k), 5'(14 + k), 5'(20 + k),
              {$urandom, $urandom}, 1'b1);
      idle(3);

      // Writeback forwarded into capture.
      step(1'b1, OP_ADD, WW_D, 5'd0, 5'd1, 5'd2, 5'd3, 64'hDEAD_BEEF_0000_0054, 1'b1);
      idle(1);
      step(1'b1, OP_OR, WW_W, 5'd2, 5'd3, 5'd4, 5'd7, {$urandom, $urandom}, 1'b1);
      idle(3);

      // RAW stall through a pended operand.
      step(1'b1, OP_SUB, WW_H, 5'd0, 5'd1, 5'd2, 5'd5, 64'h54, 1'b1);
      step(1'b1, OP_XOR, WW_B, 5'd9, 5'd8, 5'd5, 5'd6, {$urandom, $urandom}, 1'b1);
      idle(4);

      // Backpressure: three offers while ex_ready is low.
      step(1'b1, OP_SLL, WW_D, 5'd4, 5'd0, 5'd1, 5'd12, {$urandom, $urandom}, 1'b0);
      step(1'b1, OP_SRL, WW_W, 5'd5, 5'd0, 5'd1, 5'd13, {$urandom, $urandom}, 1'b0);
      step(1'b1, OP_SRA, WW_H, 5'd6, 5'd0, 5'd1, 5'd14, {$urandom, $urandom}, 1'b0);
      idle(4);

      // Asynchronous reset with the buffer full.
      step(1'b1, OP_AND, WW_D, 5'd1, 5'd2, 5'd3, 5'd16, {$urandom, $urandom}, 1'b0);
      step(1'b1, OP_OR, WW_D, 5'd2, 5'd16, 5'd3, 5'd17, {$urandom, $urandom}, 1'b0);
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      reset    = 1'b0;
      id_valid = 1'b0;
      wb_we    = 1'b0;
      flush_model();
      @(posedge clk);
      #1;
      cyc++;
      step(1'b1, OP_ADD, WW_W, 5'd3, 5'd16, 5'd17, 5'd18, {$urandom, $urandom}, 1'b1);
      idle(3);

      // Randomized traffic with frequent register reuse.
      for (int i = 0; i < 600; i++) begin
         logic [4:0] ra, rb, rd;
         ra = 5'($urandom_range(0, 7));
         rb = 5'($urandom_range(0, 7));
         rd = pick_rd();
         step($urandom_range(0, 3) != 0, 6'($urandom), 2'($urandom), 5'($urandom),
              ra, rb, rd, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      end
      idle(12);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
